sub_bytes_iter: RTL and testbench
=================================

# sub_bytes_iter

Iterative, parametrised AES SubBytes engine for the 128-bit cipher state. It supports both the forward S-box (encryption) and the inverse S-box (decryption), with the direction selected per transfer. `LANES` S-box lanes process the state over 16/`LANES` cycles, so the same block serves area-optimised and throughput-optimised round datapaths. It sits between AddRoundKey and ShiftRows in the round pipeline and uses valid/ready handshakes on both sides.

## Interface
- `LANES`, 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_valid` input 1: upstream state valid.
- `o_ready` output 1: block can accept a state this cycle.
- `i_inv` input 1: 0 selects the forward S-box, 1 selects the inverse S-box; sampled only on accept.
- `i_state` input 128: state words; byte k = bits [8k+7:8k]; word j = bits [32j+31:32j].
- `o_valid` output 1: `o_state` holds a completed result.
- `i_ready` input 1: downstream accepts the result.
- `o_state` output 128: substituted state, same byte mapping as the input; meaningful only while `o_valid` = 1.
- `o_busy` output 1: high in BUSY.

## Operation
- N = 16/`LANES` substitution cycles per state. The counter `cnt` is ceil(log2(N)) bits wide, with a minimum of 1 bit.
- Each mode has one combinational 256-entry table per lane. The forward table is the FIPS-197 S-box and the inverse table is its exact inverse. The latched mode bit selects the table output per lane.
- FSM states:
  - IDLE:
    - `o_ready` = 1.
    - When `i_valid` = 1, the block loads `i_state` into the working register, latches `i_inv`, clears `cnt` to 0 and moves to BUSY.
  - BUSY:
    - Bytes [cnt·`LANES` .. cnt·`LANES`+`LANES`−1] of the working register are replaced by their S-box images at the clock edge.
    - `cnt` increments each cycle.
    - When `cnt` = N−1, the block moves to DONE.
    - `o_ready` = 0 and `o_busy` = 1.
  - DONE:
    - `o_valid` = 1 and `o_state` = working register, both held stable until `i_ready` = 1.
    - `o_ready` = `i_ready` (combinational).
    - If `i_ready` = 1 and `i_valid` = 1, the block loads the new state and goes directly to BUSY (back-to-back, no bubble).
    - If `i_ready` = 1 and `i_valid` = 0, the block goes to IDLE.
- `i_valid` is ignored in BUSY and in DONE while `i_ready` = 0. `i_state` and `i_inv` are not sampled in those cycles.
- Bytes not yet processed are never modified. Each byte is substituted exactly once per transfer.
- `o_state` is driven directly from the working register. Its value outside DONE is unspecified to consumers.

## Timing
- Reset (asynchronous, any cycle, including mid-BUSY): state = IDLE, `cnt` = 0, working register = 0, mode = 0. Outputs: `o_valid` = 0, `o_busy` = 0, `o_ready` = 1, `o_state` = 0. Any in-flight transfer is discarded with no partial output.
- Accept occurs at edge T (`i_valid` & `o_ready`). `o_busy` = 1 during cycles T+1 … T+N. `o_valid` = 1 from cycle T+N+1.
- Latency from accept edge to first `o_valid` cycle = N+1 cycles: 2 for `LANES`=16, 5 for `LANES`=4, 17 for `LANES`=1.
- Sustained throughput with `i_ready` held at 1 = one state per N+1 cycles.
- No combinational path from `i_valid` or `i_state` to any output. One combinational path exists from `i_ready` to `o_ready`, in DONE only.
- Mode change between transfers takes effect on the next accept. Toggling `i_inv` mid-BUSY has no effect.

## Test plan
- Reset then all-zero state, `i_inv`=0, `LANES`=4 → `o_valid` rises 5 cycles after accept, `o_state` = 0x6363…63 (16 bytes), and `o_busy` is high exactly 4 cycles.
- Byte k = k (0x0F0E…0100), `i_inv`=0 → `o_state` byte0=0x63, byte1=0x7C, byte2=0x77, byte3=0x7B, byte15=0x76. Repeat with `i_inv`=1 on that result → original 0x0F0E…0100 returned.
- All bytes 0x53, `i_inv`=0 → all 0xED. All bytes 0xED, `i_inv`=1 → all 0x53. Run for `LANES` = 1, 2, 8 and 16, checking latencies of 17, 9, 3 and 2 cycles respectively.
- Backpressure: hold `i_ready`=0 for 10 cycles in DONE while `i_valid`=1 with a different state → `o_state` stable and `o_ready`=0 throughout. When `i_ready` rises, the second state is accepted that same cycle and its result follows N+1 cycles later.
- Reset pulse in the middle of BUSY (cycle T+2, `LANES`=4) → outputs take reset values immediately. A new all-zero transfer after release completes correctly to 0x63…63.
- Random state and mode over 1000 transfers with random `i_valid`/`i_ready` gaps, checked against a reference S-box model → no mismatches, no lost transfers and no duplicated transfers.

Source files
------------

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine: LANES bytes per cycle over 16/LANES cycles, forward or inverse
// S-box selected per transfer, valid/ready on both sides.
module sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_inv,
  input  logic [127:0] i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state,
  output logic         o_busy
);

  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Tables are written entry 0 first, so entry b lives at bit offset 8*(255-b) = {~b, 3'b000}.
  localparam logic [2047:0] SboxFwd = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SboxInv = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return inv ? SboxInv[idx +: 8] : SboxFwd[idx +: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    data_q, data_d;
  logic            inv_q, inv_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    inv_d   = inv_q;
    o_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_ready = 1'b1;
        if (i_valid) begin
          data_d  = i_state;
          inv_d   = i_inv;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Only the current group of LANES bytes changes; the rest pass through untouched.
        for (int l = 0; l < int'(LANES); l++) begin
          int pos;
          pos = (int'(cnt_q) * int'(LANES) + l) * 8;
          data_d[pos +: 8] = sbox(data_q[pos +: 8], inv_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        o_ready = i_ready;
        if (i_ready) begin
          if (i_valid) begin
            data_d  = i_state;
            inv_d   = i_inv;
            cnt_d   = '0;
            state_d = StBusy;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_valid = (state_q == StDone);
  assign o_busy  = (state_q == StBusy);
  assign o_state = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: directed latency/value checks plus a scoreboarded
// random run against a GF(2^8)-derived S-box model.
module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic         inv = 1'b0;
  logic         irdy = 1'b1;
  logic [127:0] st = '0;
  logic         ordy, ovld, obusy;
  logic [127:0] ostate;

  localparam int unsigned XL [4] = '{1, 2, 8, 16};
  localparam int          XLAT [4] = '{17, 9, 3, 2};

  logic [3:0]   xv = '0;
  logic [3:0]   xinv = '0;
  logic [127:0] xst [4];
  logic [3:0]   xordy, xov, xbusy;
  logic [127:0] xout [4];

  int n_vec = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;
  bit sb_en = 1'b0;
  bit rnd_en = 1'b0;
  logic [127:0] sbq [$];
  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  always #5 clk = ~clk;

  sub_bytes_iter #(.LANES(4)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .o_ready (ordy),
    .i_inv   (inv),
    .i_state (st),
    .o_valid (ovld),
    .i_ready (irdy),
    .o_state (ostate),
    .o_busy  (obusy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_x
    sub_bytes_iter #(.LANES(XL[g])) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (xv[g]),
      .o_ready (xordy[g]),
      .i_inv   (xinv[g]),
      .i_state (xst[g]),
      .o_valid (xov[g]),
      .i_ready (1'b1),
      .o_state (xout[g]),
      .o_busy  (xbusy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_calc(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    repeat (254) r = gf_mul(r, a);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = iv ? inv_m[s[8*k +: 8]] : fwd_m[s[8*k +: 8]];
    return r;
  endfunction

  // Scoreboard: push the model result on every accepted input, pop on every output handshake.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (ovld && irdy) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_output", 128'(sbq.size()), 128'd1);
        end else begin
          check("sb_state", ostate, sbq.pop_front());
          n_out++;
        end
      end
      if (valid && ordy) begin
        sbq.push_back(model(st, inv));
        n_in++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) irdy = ($urandom_range(0, 3) != 0);
  end

  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ordy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(tag, 128'd0, 128'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (obusy) bc++;
      if (ovld) break;
    end
  endtask

  task automatic xfer_main(input logic [127:0] s, input logic iv, output int lat, output int bc,
                           output logic [127:0] res);
    @(posedge clk);
    #1;
    valid = 1'b1;
    st    = s;
    inv   = iv;
    wait_accept("main_accept_timeout");
    wait_result(lat, bc);
    res = ostate;
  endtask

  task automatic xfer_x(input int g, input logic [127:0] s, input logic iv, output int lat,
                        output logic [127:0] res);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    xv[g]   = 1'b1;
    xst[g]  = s;
    xinv[g] = iv;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (xordy[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("x_accept_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    xv[g] = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (xov[g]) break;
    end
    res = xout[g];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, bc;
    logic [127:0] r, a_res, b_st, cnt_st;
    for (int i = 0; i < 4; i++) xst[i] = '0;
    for (int a = 0; a < 256; a++) fwd_m[a] = fwd_calc(8'(a));
    for (int a = 0; a < 256; a++) inv_m[fwd_m[a]] = 8'(a);
    for (int k = 0; k < 16; k++) cnt_st[8*k +: 8] = 8'(k);

    #12;
    check("reset_valid", 128'(ovld), 128'd0);
    check("reset_busy", 128'(obusy), 128'd0);
    check("reset_ready", 128'(ordy), 128'd1);
    check("reset_state", ostate, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xfer_main('0, 1'b0, lat, bc, r);
    check("zero_latency", 128'(lat), 128'd5);
    check("zero_busy_cycles", 128'(bc), 128'd4);
    check("zero_state", r, {16{8'h63}});

    xfer_main(cnt_st, 1'b0, lat, bc, r);
    check("cnt_fwd_state", r, model(cnt_st, 1'b0));
    check("cnt_fwd_b0", 128'(r[7:0]), 128'h63);
    check("cnt_fwd_b1", 128'(r[15:8]), 128'h7c);
    check("cnt_fwd_b2", 128'(r[23:16]), 128'h77);
    check("cnt_fwd_b3", 128'(r[31:24]), 128'h7b);
    check("cnt_fwd_b15", 128'(r[127:120]), 128'h76);
    xfer_main(r, 1'b1, lat, bc, r);
    check("cnt_inv_roundtrip", r, 128'h0f0e0d0c0b0a09080706050403020100);

    for (int g = 0; g < 4; g++) begin
      xfer_x(g, {16{8'h53}}, 1'b0, lat, r);
      check($sformatf("lanes%0d_fwd_latency", XL[g]), 128'(lat), 128'(XLAT[g]));
      check($sformatf("lanes%0d_fwd_state", XL[g]), r, {16{8'hed}});
      xfer_x(g, {16{8'hed}}, 1'b1, lat, r);
      check($sformatf("lanes%0d_inv_latency", XL[g]), 128'(lat), 128'(XLAT[g]));
      check($sformatf("lanes%0d_inv_state", XL[g]), r, {16{8'h53}});
    end

    // Backpressure: result held while the next state waits at the input.
    irdy = 1'b0;
    xfer_main(cnt_st, 1'b0, lat, bc, a_res);
    check("bp_first_state", a_res, model(cnt_st, 1'b0));
    b_st = 128'h00112233445566778899aabbccddeeff;
    @(posedge clk);
    #1;
    valid = 1'b1;
    st    = b_st;
    inv   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_state", ostate, a_res);
      check("bp_hold_ready", 128'(ordy), 128'd0);
    end
    @(posedge clk);
    #1;
    irdy = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 128'(ordy), 128'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    wait_result(lat, bc);
    check("bp_second_latency", 128'(lat), 128'd5);
    check("bp_second_state", ostate, model(b_st, 1'b0));

    // Reset in the middle of BUSY.
    @(posedge clk);
    #1;
    valid = 1'b1;
    st    = '0;
    inv   = 1'b0;
    wait_accept("rst_accept_timeout");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(ovld), 128'd0);
    check("midrst_busy", 128'(obusy), 128'd0);
    check("midrst_ready", 128'(ordy), 128'd1);
    check("midrst_state", ostate, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer_main('0, 1'b0, lat, bc, r);
    check("postrst_latency", 128'(lat), 128'd5);
    check("postrst_state", r, {16{8'h63}});

    // Random traffic with random gaps and backpressure.
    @(posedge clk);
    #1;
    sb_en  = 1'b1;
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      valid = 1'b1;
      st    = {$urandom, $urandom, $urandom, $urandom};
      inv   = 1'($urandom_range(0, 1));
      wait_accept("rnd_accept_timeout");
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    irdy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !ovld) break;
    end
    check("rnd_inputs", 128'(n_in), 128'd1000);
    check("rnd_outputs", 128'(n_out), 128'd1000);
    check("rnd_queue_empty", 128'(sbq.size()), 128'd0);
    sb_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
